// File: rtl/cprv_decode_stage_if.sv
// Bundle of the decode-stage handshakes and buses: IF->ID instruction offer,
// register-file read port, WB retire notification and the ID->EX payload.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface cprv_decode_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64
);

  logic                   valid_id_i;
  logic                   ready_id_o;
  logic [INSTR_WIDTH-1:0] instr_data_id_i;
  logic                   flush_i;

  logic [4:0]             rs1_addr_rf_o;
  logic [4:0]             rs2_addr_rf_o;
  logic [DATA_WIDTH-1:0]  rs1_data_rf_i;
  logic [DATA_WIDTH-1:0]  rs2_data_rf_i;

  logic                   wb_valid_i;
  logic [4:0]             wb_rd_addr_i;

  logic                   valid_ex_o;
  logic                   ready_ex_i;
  logic [DATA_WIDTH-1:0]  rs1_data_ex_o;
  logic [DATA_WIDTH-1:0]  rs2_data_ex_o;
  logic [DATA_WIDTH-1:0]  imm_data_ex_o;
  logic [4:0]             rd_addr_ex_o;
  logic                   rd_en_ex_o;
  logic                   mem_w_en_ex_o;
  logic                   illegal_ex_o;
  logic [6:0]             opcode_ex_o;
  logic [2:0]             funct3_ex_o;
  logic [6:0]             funct7_ex_o;

  modport slave (
    input  valid_id_i, instr_data_id_i, flush_i,
    input  rs1_data_rf_i, rs2_data_rf_i,
    input  wb_valid_i, wb_rd_addr_i,
    input  ready_ex_i,
    output ready_id_o,
    output rs1_addr_rf_o, rs2_addr_rf_o,
    output valid_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o,
    output rd_addr_ex_o, rd_en_ex_o, mem_w_en_ex_o, illegal_ex_o,
    output opcode_ex_o, funct3_ex_o, funct7_ex_o
  );

  modport master (
    output valid_id_i, instr_data_id_i, flush_i,
    output rs1_data_rf_i, rs2_data_rf_i,
    output wb_valid_i, wb_rd_addr_i,
    output ready_ex_i,
    input  ready_id_o,
    input  rs1_addr_rf_o, rs2_addr_rf_o,
    input  valid_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o,
    input  rd_addr_ex_o, rd_en_ex_o, mem_w_en_ex_o, illegal_ex_o,
    input  opcode_ex_o, funct3_ex_o, funct7_ex_o
  );

endinterface

// File: rtl/cprv_decode_stage.sv
// RV64 instruction decode stage: decodes the offered instruction, reads the
// register file, builds the sign-extended immediate and registers the EX payload.
// Optional feature macro CPRV_ID_SCOREBOARD_EN adds a pending-write scoreboard
// that stalls ID on RAW/WAW hazards; without it ID never stalls on hazards.
module cprv_decode_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int REG_NUM     = 32
) (
  input logic                clk,
  input logic                rst,
  cprv_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign instr  = bus.instr_data_id_i[31:0];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign bus.rs1_addr_rf_o = rs1;
  assign bus.rs2_addr_rf_o = rs2;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] imm_j;
  logic [DATA_WIDTH-1:0] imm;

  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic op_legal;
  logic writes_rd;
  logic is_store;
  logic uses_rs1;
  logic uses_rs2;
  logic illegal;
  logic rd_en;
  logic mem_w_en;

  // Opcode classification: legality, immediate format, register usage
  always_comb begin
    imm       = '0;
    op_legal  = 1'b0;
    writes_rd = 1'b0;
    is_store  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        op_legal  = 1'b1;
        writes_rd = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
        op_legal  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_i;
      end
      OPC_STORE: begin
        op_legal = 1'b1;
        is_store = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_s;
      end
      OPC_BRANCH: begin
        op_legal = 1'b1;
        uses_rs2 = 1'b1;
        imm      = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        op_legal  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_u;
      end
      OPC_JAL: begin
        op_legal  = 1'b1;
        writes_rd = 1'b1;
        imm       = imm_j;
      end
      default: begin
      end
    endcase
  end

  // Every opcode except the PC/immediate-only ones reads rs1 (illegal ones included)
  assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign illegal  = ~op_legal | (instr[1:0] != 2'b11);
  assign rd_en    = writes_rd & (rd != 5'd0) & ~illegal;
  assign mem_w_en = is_store & ~illegal;

  logic cke;
  logic hazard;
  logic accept;

  assign cke            = ~bus.valid_ex_o | bus.ready_ex_i;
  assign bus.ready_id_o = cke & ~hazard;
  assign accept         = bus.valid_id_i & bus.ready_id_o & ~bus.flush_i;

`ifdef CPRV_ID_SCOREBOARD_EN
  logic [REG_NUM-1:0] sb;
  logic [REG_NUM-1:0] sb_next;

  // Pending-write bits: clears from flush and WB first, so a same-index set wins
  always_comb begin
    sb_next = sb;
    if (bus.flush_i && bus.valid_ex_o && bus.rd_en_ex_o) begin
      sb_next[bus.rd_addr_ex_o] = 1'b0;
    end
    if (bus.wb_valid_i) begin
      sb_next[bus.wb_rd_addr_i] = 1'b0;
    end
    if (accept && rd_en) begin
      sb_next[rd] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  assign hazard = bus.valid_id_i & ((sb[rs1] & uses_rs1) | (sb[rs2] & uses_rs2) | (sb[rd] & rd_en));
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = bus.wb_valid_i ^ (^bus.wb_rd_addr_i) ^ uses_rs1 ^ uses_rs2;
  assign hazard = 1'b0;
`endif

  // EX payload loads only on accept, so bubbles and stalls leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rs1_data_ex_o <= '0;
      bus.rs2_data_ex_o <= '0;
      bus.imm_data_ex_o <= '0;
      bus.rd_addr_ex_o  <= '0;
      bus.rd_en_ex_o    <= 1'b0;
      bus.mem_w_en_ex_o <= 1'b0;
      bus.illegal_ex_o  <= 1'b0;
      bus.opcode_ex_o   <= '0;
      bus.funct3_ex_o   <= '0;
      bus.funct7_ex_o   <= '0;
    end else if (accept) begin
      bus.rs1_data_ex_o <= bus.rs1_data_rf_i;
      bus.rs2_data_ex_o <= bus.rs2_data_rf_i;
      bus.imm_data_ex_o <= imm;
      bus.rd_addr_ex_o  <= rd;
      bus.rd_en_ex_o    <= rd_en;
      bus.mem_w_en_ex_o <= mem_w_en;
      bus.illegal_ex_o  <= illegal;
      bus.opcode_ex_o   <= opcode;
      bus.funct3_ex_o   <= instr[14:12];
      bus.funct7_ex_o   <= instr[31:25];
    end
  end

  // EX valid: flush kills unconditionally, otherwise advances whenever EX can take data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_ex_o <= 1'b0;
    end else if (bus.flush_i) begin
      bus.valid_ex_o <= 1'b0;
    end else if (cke) begin
      bus.valid_ex_o <= accept;
    end
  end

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Bench for cprv_decode_stage: directed scenarios followed by random traffic.
// A reference model predicts ready/valid and the decoded payload; accepted
// instructions are queued and a monitor compares them as they leave EX.
module tb_cprv_decode_stage;

  localparam logic [6:0] M_LOAD      = 7'h03;
  localparam logic [6:0] M_OP_IMM    = 7'h13;
  localparam logic [6:0] M_AUIPC     = 7'h17;
  localparam logic [6:0] M_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] M_STORE     = 7'h23;
  localparam logic [6:0] M_OP        = 7'h33;
  localparam logic [6:0] M_LUI       = 7'h37;
  localparam logic [6:0] M_OP_32     = 7'h3B;
  localparam logic [6:0] M_BRANCH    = 7'h63;
  localparam logic [6:0] M_JALR      = 7'h67;
  localparam logic [6:0] M_JAL       = 7'h6F;

  typedef struct {
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rd_en;
    logic        mem_w_en;
    logic        illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        uses_rs1;
    logic        uses_rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cprv_decode_stage_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  cprv_decode_stage #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .REG_NUM(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  exp_t mon_exp;
  bit   m_valid;
  exp_t m_ex;
  bit   sb_model[32];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sign-extend a bits-wide two's complement value held as a non-negative number
  function automatic longint sext(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    if (v >= half) return v - 2 * half;
    return v;
  endfunction

  // Architectural decode of one instruction straight from the ISA field rules
  function automatic exp_t decode_model(input logic [31:0] instr, input logic [63:0] d1, input logic [63:0] d2);
    exp_t   e;
    logic [6:0] op;
    longint imm;
    bit     legal;
    bit     writer;
    op    = instr[6:0];
    imm   = 0;
    legal = (op inside {M_LOAD, M_OP_IMM, M_AUIPC, M_OP_IMM_32, M_STORE, M_OP, M_LUI,
                        M_OP_32, M_BRANCH, M_JALR, M_JAL}) && (instr[1:0] == 2'b11);
    writer = op inside {M_OP, M_OP_32, M_OP_IMM, M_OP_IMM_32, M_LOAD, M_LUI, M_AUIPC, M_JAL, M_JALR};
    if (op inside {M_LOAD, M_OP_IMM, M_OP_IMM_32, M_JALR})
      imm = sext(longint'(instr[31:20]), 12);
    else if (op == M_STORE)
      imm = sext(longint'(instr[31:25]) * 32 + longint'(instr[11:7]), 12);
    else if (op == M_BRANCH)
      imm = sext(longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048 +
                 longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2, 13);
    else if (op inside {M_LUI, M_AUIPC})
      imm = sext(longint'(instr[31:12]) * 4096, 32);
    else if (op == M_JAL)
      imm = sext(longint'(instr[31]) * 1048576 + longint'(instr[19:12]) * 4096 +
                 longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2, 21);
    e.rs1_data = d1;
    e.rs2_data = d2;
    e.imm      = 64'(imm);
    e.rd       = instr[11:7];
    e.illegal  = !legal;
    e.rd_en    = legal && writer && (instr[11:7] != 5'd0);
    e.mem_w_en = legal && (op == M_STORE);
    e.opcode   = op;
    e.funct3   = instr[14:12];
    e.funct7   = instr[31:25];
    e.uses_rs1 = !(op inside {M_LUI, M_AUIPC, M_JAL});
    e.uses_rs2 = op inside {M_OP, M_OP_32, M_STORE, M_BRANCH};
    return e;
  endfunction

  // One clock of stimulus: drive inputs, check handshake against the model, advance model
  task automatic applyStimulus(input bit v, input logic [31:0] instr, input bit rex,
                               input bit fl, input bit wbv, input logic [4:0] wbr);
    logic [63:0] d1;
    logic [63:0] d2;
    exp_t d;
    bit   hz;
    bit   cke;
    bit   rdy;
    bit   acc;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    bus.valid_id_i      = v;
    bus.instr_data_id_i = instr;
    bus.ready_ex_i      = rex;
    bus.flush_i         = fl;
    bus.wb_valid_i      = wbv;
    bus.wb_rd_addr_i    = wbr;
    bus.rs1_data_rf_i   = d1;
    bus.rs2_data_rf_i   = d2;
    #1;
    d   = decode_model(instr, d1, d2);
    cke = !m_valid || rex;
`ifdef CPRV_ID_SCOREBOARD_EN
    hz = v && ((sb_model[instr[19:15]] && d.uses_rs1) || (sb_model[instr[24:20]] && d.uses_rs2) ||
               (sb_model[d.rd] && d.rd_en));
`else
    hz = 1'b0;
`endif
    rdy = cke && !hz;
    acc = v && rdy && !fl;
    checkOutput("ready_id", 64'(bus.ready_id_o), 64'(rdy));
    checkOutput("valid_ex", 64'(bus.valid_ex_o), 64'(m_valid));
    checkOutput("rs1_addr", 64'(bus.rs1_addr_rf_o), 64'(instr[19:15]));
    checkOutput("rs2_addr", 64'(bus.rs2_addr_rf_o), 64'(instr[24:20]));
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    if (fl && m_valid && m_ex.rd_en) sb_model[m_ex.rd] = 1'b0;
    if (wbv) sb_model[wbr] = 1'b0;
    if (acc && d.rd_en) sb_model[d.rd] = 1'b1;
    sb_model[0] = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
    end else if (cke) begin
      m_valid = acc;
    end
    if (acc) m_ex = d;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(0, 12))
      0:  op = M_LOAD;
      1:  op = M_OP_IMM;
      2:  op = M_AUIPC;
      3:  op = M_OP_IMM_32;
      4:  op = M_STORE;
      5:  op = M_OP;
      6:  op = M_LUI;
      7:  op = M_OP_32;
      8:  op = M_BRANCH;
      9:  op = M_JALR;
      10: op = M_JAL;
      default: op = 7'($urandom);
    endcase
    w        = $urandom;
    w[6:0]   = op;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  // Monitor: whenever an instruction leaves EX (taken or flushed) compare it with the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.valid_ex_o && (bus.ready_ex_i || bus.flush_i)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_ex_item", 64'(1), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("ex_rs1_data", bus.rs1_data_ex_o, mon_exp.rs1_data);
        checkOutput("ex_rs2_data", bus.rs2_data_ex_o, mon_exp.rs2_data);
        checkOutput("ex_imm", bus.imm_data_ex_o, mon_exp.imm);
        checkOutput("ex_rd_addr", 64'(bus.rd_addr_ex_o), 64'(mon_exp.rd));
        checkOutput("ex_rd_en", 64'(bus.rd_en_ex_o), 64'(mon_exp.rd_en));
        checkOutput("ex_mem_w_en", 64'(bus.mem_w_en_ex_o), 64'(mon_exp.mem_w_en));
        checkOutput("ex_illegal", 64'(bus.illegal_ex_o), 64'(mon_exp.illegal));
        checkOutput("ex_opcode", 64'(bus.opcode_ex_o), 64'(mon_exp.opcode));
        checkOutput("ex_funct3", 64'(bus.funct3_ex_o), 64'(mon_exp.funct3));
        checkOutput("ex_funct7", 64'(bus.funct7_ex_o), 64'(mon_exp.funct7));
      end
    end
  end

  initial begin
    m_valid = 1'b0;
    foreach (sb_model[i]) sb_model[i] = 1'b0;
    rst                 = 1'b1;
    bus.valid_id_i      = 1'b1;
    bus.instr_data_id_i = 32'h00500093;
    bus.ready_ex_i      = 1'b0;
    bus.flush_i         = 1'b0;
    bus.wb_valid_i      = 1'b0;
    bus.wb_rd_addr_i    = '0;
    bus.rs1_data_rf_i   = '0;
    bus.rs2_data_rf_i   = '0;

    // Reset: EX empty and zeroed, ID ready
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_ready_id", 64'(bus.ready_id_o), 64'(1));
    checkOutput("reset_valid_ex", 64'(bus.valid_ex_o), 64'(0));
    checkOutput("reset_rd_en", 64'(bus.rd_en_ex_o), 64'(0));
    checkOutput("reset_imm", bus.imm_data_ex_o, 64'(0));
    checkOutput("reset_opcode", 64'(bus.opcode_ex_o), 64'(0));
    checkOutput("reset_illegal", 64'(bus.illegal_ex_o), 64'(0));
    rst = 1'b0;

    // addi x1,x0,5
    applyStimulus(1, 32'h00500093, 1, 0, 0, 5'd0);
    checkOutput("addi_valid", 64'(bus.valid_ex_o), 64'(1));
    checkOutput("addi_rd", 64'(bus.rd_addr_ex_o), 64'(1));
    checkOutput("addi_rd_en", 64'(bus.rd_en_ex_o), 64'(1));
    checkOutput("addi_imm", bus.imm_data_ex_o, 64'(5));
    checkOutput("addi_opcode", 64'(bus.opcode_ex_o), 64'(7'h13));
    applyStimulus(0, 32'h0, 1, 0, 1, 5'd1);

    // sw x2,-4(x1), then hold it in EX for three cycles
    applyStimulus(1, 32'hFE20AE23, 1, 0, 0, 5'd0);
    checkOutput("sw_imm", bus.imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("sw_mem_w_en", 64'(bus.mem_w_en_ex_o), 64'(1));
    checkOutput("sw_rd_en", 64'(bus.rd_en_ex_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h00700213, 0, 0, 0, 5'd0);
      checkOutput("stall_valid", 64'(bus.valid_ex_o), 64'(1));
      checkOutput("stall_imm", bus.imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("stall_opcode", 64'(bus.opcode_ex_o), 64'(7'h23));
    end
    applyStimulus(0, 32'h0, 1, 0, 0, 5'd0);

    // addi x1 then add x2,x1,x1 waiting on the x1 writeback
    applyStimulus(1, 32'h00500093, 1, 0, 0, 5'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h00108133, 1, 0, 0, 5'd0);
    applyStimulus(1, 32'h00108133, 1, 0, 1, 5'd1);
    applyStimulus(1, 32'h00108133, 1, 0, 0, 5'd0);
    checkOutput("add_rd", 64'(bus.rd_addr_ex_o), 64'(2));
    applyStimulus(0, 32'h0, 1, 0, 1, 5'd2);

    // addi x3 held in EX and flushed; a reader of x3 must then proceed
    applyStimulus(1, 32'h00500193, 1, 0, 0, 5'd0);
    applyStimulus(0, 32'h0, 0, 1, 0, 5'd0);
    checkOutput("flush_valid", 64'(bus.valid_ex_o), 64'(0));
    applyStimulus(1, 32'h00118213, 0, 0, 0, 5'd0);
    checkOutput("post_flush_rd", 64'(bus.rd_addr_ex_o), 64'(4));
    applyStimulus(0, 32'h0, 1, 0, 1, 5'd4);

    // Illegal opcode
    applyStimulus(1, 32'h0000007F, 1, 0, 0, 5'd0);
    checkOutput("illegal_flag", 64'(bus.illegal_ex_o), 64'(1));
    checkOutput("illegal_rd_en", 64'(bus.rd_en_ex_o), 64'(0));
    checkOutput("illegal_mem_w", 64'(bus.mem_w_en_ex_o), 64'(0));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4,
                    5'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 0, 0, 5'd0);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
